dmem_arbiter: RTL
=================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter NB_DATA, default 32: data word width.
REQ-002 SHALL have parameter NB_ADDR, default 7: word address width.
REQ-003 SHALL have parameter N_ELEMENTS, default 128: memory depth in words.
REQ-004 SHALL have ports:
- clock_i  in  1  single clock; all state updates on the rising edge.
- reset_i  in  1  synchronous, active-low reset.
- pipe_enable_i  in  1  MEM stage enable.
- pipe_addr_i  in  NB_ADDR  pipeline address.
- pipe_wdata_i  in  NB_DATA  pipeline write data.
- pipe_read_i  in  1  pipeline read.
- pipe_write_i  in  1  pipeline write.
- pipe_halt_i  in  1  pipeline halted or in debug step.
- pipe_stall_o  out  1  pipeline must freeze.
- dbg_req_i  in  1  debug single-word read request, level.
- dbg_addr_i  in  NB_ADDR  debug address.
- dbg_ack_o  out  1  one-cycle pulse: dbg_rdata_o valid.
- dbg_rdata_o  out  NB_DATA  registered debug read data.
- mem_enable_o  out  1  to memory enable.
- mem_addr_o  out  NB_ADDR  to memory address.
- mem_wdata_o  out  NB_DATA  to memory write data.
- mem_read_o  out  1  to memory read strobe.
- mem_write_o  out  1  to memory write strobe.
- mem_rdata_i  in  NB_DATA  memory read data; registered on the falling clock edge.

Function
REQ-005 SHALL implement the FSM states IDLE, DBG_RD, DBG_ACK.
REQ-006 SHALL, in IDLE, pass the pipe_* signals combinationally to the mem_* outputs.
REQ-007 SHALL move IDLE->DBG_RD only when dbg_req_i=1 and pipe_halt_i=1, capturing dbg_addr_i into an internal register.
REQ-008 SHALL, in DBG_RD, drive mem_enable_o=1, mem_read_o=1, mem_write_o=0 and mem_addr_o=the captured address, ignoring the pipe_* signals.
REQ-009 SHALL, on the DBG_RD->DBG_ACK edge, load mem_rdata_i into dbg_rdata_o.
REQ-010 SHALL, in DBG_ACK, assert dbg_ack_o for exactly one cycle, then return to IDLE.
REQ-011 Latency: with dbg_req_i sampled at rising edge k, dbg_ack_o SHALL be high during cycle k+1 to k+2.
REQ-012 SHALL assert pipe_stall_o in DBG_RD and DBG_ACK, even if pipe_halt_i deasserts mid-access; an access in progress always completes.
REQ-013 SHALL hold dbg_rdata_o until the next load.
REQ-014 SHALL NOT re-enter DBG_RD in the cycle after DBG_ACK; the debug unit must drop dbg_req_i for at least one cycle or it is re-served from IDLE.
REQ-015 SHALL ignore dbg_req_i while pipe_halt_i=0; pipeline traffic has absolute priority.
REQ-016 SHALL force mem_write_o=0 for any non-IDLE state, so debug accesses never write memory.

Reset
REQ-017 When reset_i=0 at a rising edge, SHALL go to IDLE and clear dbg_rdata_o, dbg_ack_o, the captured address and the dump counter, regardless of the current state.
REQ-018 SHALL drive pipe_stall_o=0 and dbg_ack_o=0 in the cycle after reset.

Configuration
REQ-019 SHALL support the macro DMEM_ARB_DUMP_EN.
REQ-020 With DMEM_ARB_DUMP_EN defined, SHALL have the ports:
- dbg_dump_i  in  1  dump request pulse.
- dbg_ready_i  in  1  debug consumer ready.
- dbg_last_o  out  1  last word of the dump.
REQ-021 With DMEM_ARB_DUMP_EN defined, SHALL add the states DUMP_RD and DUMP_HOLD:
- Entry: from IDLE on dbg_dump_i=1 and pipe_halt_i=1; dbg_dump_i wins over dbg_req_i if both are set.
- DUMP_RD reads counter address, then DUMP_HOLD loads dbg_rdata_o and asserts dbg_ack_o.
- dbg_ack_o is held until dbg_ready_i=1.
- On handshake the counter increments and the FSM returns to DUMP_RD.
- After word N_ELEMENTS-1, dbg_last_o=1 with that ack; the counter wraps to 0 and the FSM goes to IDLE.
- pipe_stall_o=1 for the whole dump.
REQ-022 Without DMEM_ARB_DUMP_EN, SHALL omit these ports, states and counter.

Structure
REQ-023 SHALL take the FSM state encoding and the NB_DATA/NB_ADDR/N_ELEMENTS defaults from the shared package mips_pkg.
REQ-024 SHALL be a single module, with no sub-module.

Verification
REQ-025 Bench SHALL cover pass-through: pipe_write_i=1, addr 5, data 0xDEADBEEF, halt=0 -> mem_write_o=1, mem_addr_o=5 in the same cycle; pipe_stall_o=0.
REQ-026 Bench SHALL cover debug read: preload word 5=0xDEADBEEF, halt=1, dbg_req_i=1 with addr 5 -> pipe_stall_o=1 for 2 cycles, then dbg_ack_o pulse with dbg_rdata_o=0xDEADBEEF.
REQ-027 Bench SHALL cover priority: dbg_req_i=1 with halt=0 for 10 cycles -> no dbg_ack_o, mem_* follow pipe_*.
REQ-028 Bench SHALL cover halt drop: halt falls during DBG_RD -> access completes, ack pulse, stall drops the cycle after DBG_ACK.
REQ-029 Bench SHALL cover reset mid-access: reset_i=0 in DBG_RD -> next cycle IDLE, dbg_ack_o=0, dbg_rdata_o=0.
REQ-030 Bench SHALL cover dump (DMEM_ARB_DUMP_EN): memory[i]=i*3, dbg_ready_i toggling -> 128 acks, values 0..381 in order, dbg_last_o only on value 381, then IDLE.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS data-memory path.
//   - Default widths/depth for the data memory and its arbiter.
//   - State encoding of the dmem_arbiter FSM.
// Optional feature macro: DMEM_ARB_DUMP_EN adds the sequential memory-dump states.
package mips_pkg;

    localparam int unsigned NB_DATA_DEF    = 32;
    localparam int unsigned NB_ADDR_DEF    = 7;
    localparam int unsigned N_ELEMENTS_DEF = 128;

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StDbgRd    = 3'd1,
`ifdef DMEM_ARB_DUMP_EN
        StDbgAck   = 3'd2,
        StDumpRd   = 3'd3,
        StDumpHold = 3'd4
`else
        StDbgAck   = 3'd2
`endif
    } dmem_arb_state_e;

endpackage

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter between the pipeline MEM stage and the debug unit.
// The pipeline owns the memory (combinational pass-through) unless it is halted and the
// debug unit requests a single-word read; debug reads stall the pipeline until complete.
//
// Ports:
//   clock_i, reset_i          clock, synchronous active-low reset
//   pipe_*_i / pipe_stall_o   pipeline MEM-stage request and freeze
//   dbg_req_i, dbg_addr_i     debug single-word read request (level) and address
//   dbg_ack_o, dbg_rdata_o    read-data-valid pulse and registered read data
//   mem_*_o, mem_rdata_i      memory port (read data registered by memory on falling edge)
//   dbg_dump_i, dbg_ready_i,
//   dbg_last_o                whole-memory dump handshake (only with DMEM_ARB_DUMP_EN)
//
// Optional feature macro: DMEM_ARB_DUMP_EN.
module dmem_arbiter
    import mips_pkg::*;
#(
    parameter int unsigned NB_DATA    = NB_DATA_DEF,
    parameter int unsigned NB_ADDR    = NB_ADDR_DEF,
    parameter int unsigned N_ELEMENTS = N_ELEMENTS_DEF
) (
    input  logic               clock_i,
    input  logic               reset_i,
    input  logic               pipe_enable_i,
    input  logic [NB_ADDR-1:0] pipe_addr_i,
    input  logic [NB_DATA-1:0] pipe_wdata_i,
    input  logic               pipe_read_i,
    input  logic               pipe_write_i,
    input  logic               pipe_halt_i,
    output logic               pipe_stall_o,
    input  logic               dbg_req_i,
    input  logic [NB_ADDR-1:0] dbg_addr_i,
    output logic               dbg_ack_o,
    output logic [NB_DATA-1:0] dbg_rdata_o,
`ifdef DMEM_ARB_DUMP_EN
    input  logic               dbg_dump_i,
    input  logic               dbg_ready_i,
    output logic               dbg_last_o,
`endif
    output logic               mem_enable_o,
    output logic [NB_ADDR-1:0] mem_addr_o,
    output logic [NB_DATA-1:0] mem_wdata_o,
    output logic               mem_read_o,
    output logic               mem_write_o,
    input  logic [NB_DATA-1:0] mem_rdata_i
);

    dmem_arb_state_e    state_q, state_d;
    logic [NB_ADDR-1:0] addr_q;
    logic [NB_DATA-1:0] rdata_q;

`ifdef DMEM_ARB_DUMP_EN
    localparam logic [NB_ADDR-1:0] LastAddr = NB_ADDR'(N_ELEMENTS - 1);

    logic [NB_ADDR-1:0] cnt_q;
    logic               dump_last;

    assign dump_last = (cnt_q == LastAddr);
`else
    // Depth only matters for the dump counter wrap.
    logic [31:0] unused_n_elements;
    assign unused_n_elements = N_ELEMENTS;
`endif

    // State register and datapath registers.
    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            state_q <= StIdle;
            addr_q  <= '0;
            rdata_q <= '0;
`ifdef DMEM_ARB_DUMP_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            if (state_q == StIdle && state_d == StDbgRd) begin
                addr_q <= dbg_addr_i;
            end
            // Memory data is valid by the rising edge that leaves a read state.
            if (state_q == StDbgRd) begin
                rdata_q <= mem_rdata_i;
            end
`ifdef DMEM_ARB_DUMP_EN
            if (state_q == StDumpRd) begin
                rdata_q <= mem_rdata_i;
            end
            if (state_q == StDumpHold && dbg_ready_i) begin
                cnt_q <= dump_last ? '0 : cnt_q + NB_ADDR'(1);
            end
`endif
        end
    end

    // Next-state logic. Debug requests are only honoured while the pipeline is halted.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (pipe_halt_i) begin
`ifdef DMEM_ARB_DUMP_EN
                    if (dbg_dump_i) begin
                        state_d = StDumpRd;
                    end else if (dbg_req_i) begin
                        state_d = StDbgRd;
                    end
`else
                    if (dbg_req_i) begin
                        state_d = StDbgRd;
                    end
`endif
                end
            end
            StDbgRd:  state_d = StDbgAck;
            StDbgAck: state_d = StIdle;
`ifdef DMEM_ARB_DUMP_EN
            StDumpRd: state_d = StDumpHold;
            StDumpHold: begin
                if (dbg_ready_i) begin
                    state_d = dump_last ? StIdle : StDumpRd;
                end
            end
`endif
            default:  state_d = StIdle;
        endcase
    end

    // Outputs. Outside IDLE the pipeline is ignored and memory is never written.
    always_comb begin
        mem_enable_o = 1'b0;
        mem_addr_o   = '0;
        mem_wdata_o  = '0;
        mem_read_o   = 1'b0;
        mem_write_o  = 1'b0;
        pipe_stall_o = 1'b1;
        dbg_ack_o    = 1'b0;
`ifdef DMEM_ARB_DUMP_EN
        dbg_last_o   = 1'b0;
`endif
        unique case (state_q)
            StIdle: begin
                mem_enable_o = pipe_enable_i;
                mem_addr_o   = pipe_addr_i;
                mem_wdata_o  = pipe_wdata_i;
                mem_read_o   = pipe_read_i;
                mem_write_o  = pipe_write_i;
                pipe_stall_o = 1'b0;
            end
            StDbgRd: begin
                mem_enable_o = 1'b1;
                mem_addr_o   = addr_q;
                mem_read_o   = 1'b1;
            end
            StDbgAck: begin
                dbg_ack_o = 1'b1;
            end
`ifdef DMEM_ARB_DUMP_EN
            StDumpRd: begin
                mem_enable_o = 1'b1;
                mem_addr_o   = cnt_q;
                mem_read_o   = 1'b1;
            end
            StDumpHold: begin
                dbg_ack_o  = 1'b1;
                dbg_last_o = dump_last;
            end
`endif
            default: begin
                pipe_stall_o = 1'b1;
            end
        endcase
    end

    assign dbg_rdata_o = rdata_q;

endmodule
